// File: rtl/ras_ckpt.sv
// ras_ckpt: circular-buffer return address stack with per-prediction
// checkpoint and exact mispredict repair, for the fetch stage.
// Optional feature macro: RAS_ALT_LINK_EN (x5/t0 also acts as a link register).
module ras_ckpt #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 32,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    input  logic              j_type_i,
    input  logic              jr_type_i,
    input  logic [4:0]        rd_addr_i,
    input  logic [4:0]        r1_addr_i,
    input  logic [ADDR_W-1:0] return_addr_i,
    input  logic              flush_i,
    input  logic              restore_valid_i,
    input  logic [PTR_W-1:0]  restore_tos_i,
    input  logic [CNT_W-1:0]  restore_cnt_i,
    input  logic [ADDR_W-1:0] restore_data_i,
    output logic              pop_valid_o,
    output logic [ADDR_W-1:0] pop_data_o,
    output logic [PTR_W-1:0]  ckpt_tos_o,
    output logic [CNT_W-1:0]  ckpt_cnt_o,
    output logic [ADDR_W-1:0] ckpt_data_o,
    output logic              overflow_o
);

    typedef enum logic [1:0] {
        OP_NONE,
        OP_PUSH,
        OP_POP,
        OP_BOTH
    } op_e;

    logic [ADDR_W-1:0] entry_q [DEPTH];
    logic [PTR_W-1:0]  tos_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              overflow_q;

    op_e              op;
    logic             link_rd;
    logic             link_rs1;
    logic [PTR_W-1:0] tos_inc;
    logic [PTR_W-1:0] tos_dec;
    logic             full;
    logic             empty;

    function automatic logic is_link(input logic [4:0] x);
`ifdef RAS_ALT_LINK_EN
        return (x == 5'd1) || (x == 5'd5);
`else
        return (x == 5'd1);
`endif
    endfunction

    assign link_rd  = is_link(rd_addr_i);
    assign link_rs1 = is_link(r1_addr_i);

    // Pointer arithmetic wraps naturally because DEPTH is a power of two.
    assign tos_inc = tos_q + PTR_W'(1);
    assign tos_dec = tos_q - PTR_W'(1);
    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);

    // Decode the predecoded jump into a stack operation.
    always_comb begin
        // NOTE: assigning a default first keeps every path covered, so no latch is inferred.
        op = OP_NONE;
        if (req_valid_i) begin
            if (j_type_i && link_rd) begin
                op = OP_PUSH;
            end else if (jr_type_i) begin
                if (link_rd && link_rs1) begin
                    op = (rd_addr_i == r1_addr_i) ? OP_PUSH : OP_BOTH;
                end else if (link_rs1) begin
                    op = OP_POP;
                end else if (link_rd) begin
                    op = OP_PUSH;
                end
            end
        end
    end

    // Zero-latency prediction and pre-update checkpoint.
    assign pop_data_o  = entry_q[tos_q];
    assign pop_valid_o = !rst_i && !restore_valid_i && !flush_i && !empty &&
                         ((op == OP_POP) || (op == OP_BOTH));
    assign ckpt_tos_o  = tos_q;
    assign ckpt_cnt_o  = cnt_q;
    assign ckpt_data_o = entry_q[tos_q];
    assign overflow_o  = overflow_q;

    // Stack state update: reset > restore > flush > request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: non-blocking assignments for all sequential state avoid simulation races.
            tos_q      <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
            // NOTE: the entries are cleared on reset so a repaired or wrapped read never sees X.
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            overflow_q <= 1'b0;
            if (restore_valid_i) begin
                tos_q                  <= restore_tos_i;
                cnt_q                  <= restore_cnt_i;
                entry_q[restore_tos_i] <= restore_data_i;
            end else if (flush_i) begin
                cnt_q <= '0;
            end else begin
                case (op)
                    OP_PUSH: begin
                        tos_q            <= tos_inc;
                        entry_q[tos_inc] <= return_addr_i;
                        if (full) begin
                            overflow_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    OP_POP: begin
                        if (!empty) begin
                            tos_q <= tos_dec;
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    OP_BOTH: begin
                        entry_q[tos_q] <= return_addr_i;
                        if (empty) begin
                            cnt_q <= CNT_W'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ras_ckpt.sv
// tb_ras_ckpt: directed scoreboard bench for ras_ckpt (DEPTH=8, ADDR_W=32).
// The driver queues the hand-computed expectation for each cycle; a monitor
// on the falling edge pops it and compares against the DUT outputs.
module tb_ras_ckpt;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 32;
    localparam int PTR_W  = 3;
    localparam int CNT_W  = 4;

`ifdef RAS_ALT_LINK_EN
    localparam logic       BOTH_PV  = 1'b1;
    localparam logic [2:0] BOTH_TOS = 3'd1;
    localparam logic [3:0] BOTH_CNT = 4'd1;
`else
    localparam logic       BOTH_PV  = 1'b0;
    localparam logic [2:0] BOTH_TOS = 3'd2;
    localparam logic [3:0] BOTH_CNT = 4'd2;
`endif

    localparam logic [4:0] M_PV = 5'b00001;
    localparam logic [4:0] M_PD = 5'b00010;
    localparam logic [4:0] M_CK = 5'b00100;
    localparam logic [4:0] M_CD = 5'b01000;
    localparam logic [4:0] M_OV = 5'b10000;

    typedef struct {
        logic [4:0]        mask;
        logic              pv;
        logic [ADDR_W-1:0] pd;
        logic [PTR_W-1:0]  tos;
        logic [CNT_W-1:0]  cnt;
        logic [ADDR_W-1:0] ckd;
        logic              ov;
    } exp_t;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              req_valid_i;
    logic              j_type_i;
    logic              jr_type_i;
    logic [4:0]        rd_addr_i;
    logic [4:0]        r1_addr_i;
    logic [ADDR_W-1:0] return_addr_i;
    logic              flush_i;
    logic              restore_valid_i;
    logic [PTR_W-1:0]  restore_tos_i;
    logic [CNT_W-1:0]  restore_cnt_i;
    logic [ADDR_W-1:0] restore_data_i;
    logic              pop_valid_o;
    logic [ADDR_W-1:0] pop_data_o;
    logic [PTR_W-1:0]  ckpt_tos_o;
    logic [CNT_W-1:0]  ckpt_cnt_o;
    logic [ADDR_W-1:0] ckpt_data_o;
    logic              overflow_o;

    exp_t  exp_q [$];
    string name_q [$];
    int    n_tests = 0;
    int    n_fail  = 0;

    ras_ckpt #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .req_valid_i     (req_valid_i),
        .j_type_i        (j_type_i),
        .jr_type_i       (jr_type_i),
        .rd_addr_i       (rd_addr_i),
        .r1_addr_i       (r1_addr_i),
        .return_addr_i   (return_addr_i),
        .flush_i         (flush_i),
        .restore_valid_i (restore_valid_i),
        .restore_tos_i   (restore_tos_i),
        .restore_cnt_i   (restore_cnt_i),
        .restore_data_i  (restore_data_i),
        .pop_valid_o     (pop_valid_o),
        .pop_data_o      (pop_data_o),
        .ckpt_tos_o      (ckpt_tos_o),
        .ckpt_cnt_o      (ckpt_cnt_o),
        .ckpt_data_o     (ckpt_data_o),
        .overflow_o      (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic exp_t mk(input logic [4:0] m, input logic pv, input logic [31:0] pd,
                                input logic [2:0] tos, input logic [3:0] cnt,
                                input logic [31:0] ckd, input logic ov);
        exp_t e;
        e.mask = m;
        e.pv   = pv;
        e.pd   = pd;
        e.tos  = tos;
        e.cnt  = cnt;
        e.ckd  = ckd;
        e.ov   = ov;
        return e;
    endfunction

    task automatic check(input string nm, input string field,
                         input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, field, act, expv);
        end
    endtask

    // Monitor: compare the outputs presented this cycle with the queued expectation.
    exp_t  mon_e;
    string mon_nm;
    always @(negedge clk_i) begin
        if (exp_q.size() > 0) begin
            mon_e  = exp_q.pop_front();
            mon_nm = name_q.pop_front();
            if (mon_e.mask[0]) check(mon_nm, "pop_valid", 32'(pop_valid_o), 32'(mon_e.pv));
            if (mon_e.mask[1]) check(mon_nm, "pop_data", pop_data_o, mon_e.pd);
            if (mon_e.mask[2]) begin
                check(mon_nm, "ckpt_tos", 32'(ckpt_tos_o), 32'(mon_e.tos));
                check(mon_nm, "ckpt_cnt", 32'(ckpt_cnt_o), 32'(mon_e.cnt));
            end
            if (mon_e.mask[3]) check(mon_nm, "ckpt_data", ckpt_data_o, mon_e.ckd);
            if (mon_e.mask[4]) check(mon_nm, "overflow", 32'(overflow_o), 32'(mon_e.ov));
        end
    end

    task automatic clr();
        rst_i           = 1'b0;
        req_valid_i     = 1'b0;
        j_type_i        = 1'b0;
        jr_type_i       = 1'b0;
        rd_addr_i       = 5'd0;
        r1_addr_i       = 5'd0;
        return_addr_i   = '0;
        flush_i         = 1'b0;
        restore_valid_i = 1'b0;
        restore_tos_i   = '0;
        restore_cnt_i   = '0;
        restore_data_i  = '0;
    endtask

    task automatic jal(input logic [31:0] ret);
        req_valid_i   = 1'b1;
        j_type_i      = 1'b1;
        rd_addr_i     = 5'd1;
        return_addr_i = ret;
    endtask

    task automatic jalr(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] ret);
        req_valid_i   = 1'b1;
        jr_type_i     = 1'b1;
        rd_addr_i     = rd;
        r1_addr_i     = rs1;
        return_addr_i = ret;
    endtask

    task automatic pop();
        jalr(5'd0, 5'd1, 32'h0);
    endtask

    task automatic restore(input logic [2:0] t, input logic [3:0] c, input logic [31:0] d);
        restore_valid_i = 1'b1;
        restore_tos_i   = t;
        restore_cnt_i   = c;
        restore_data_i  = d;
    endtask

    // Queue the expectation for the cycle whose inputs are now applied, then advance.
    task automatic cyc(input string nm, input exp_t e);
        name_q.push_back(nm);
        exp_q.push_back(e);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        clr();
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;

        // Reset state, with a pop request that must stay invalid.
        clr(); rst_i = 1'b1; pop();
        cyc("reset", mk(M_PV | M_CK | M_CD | M_OV, 1'b0, 0, 3'd0, 4'd0, 0, 1'b0));

        // Basic push/pop and underflow.
        clr(); jal(32'h100);
        cyc("push1", mk(M_PV | M_CK, 1'b0, 0, 3'd0, 4'd0, 0, 1'b0));
        clr(); jal(32'h200);
        cyc("push2", mk(M_CK | M_CD, 1'b0, 0, 3'd1, 4'd1, 32'h100, 1'b0));
        clr(); pop();
        cyc("pop1", mk(M_PV | M_PD | M_CK, 1'b1, 32'h200, 3'd2, 4'd2, 0, 1'b0));
        clr(); pop();
        cyc("pop2", mk(M_PV | M_PD | M_CK, 1'b1, 32'h100, 3'd1, 4'd1, 0, 1'b0));
        clr(); pop();
        cyc("pop_under", mk(M_PV | M_CK, 1'b0, 0, 3'd0, 4'd0, 0, 1'b0));
        clr(); req_valid_i = 1'b1; j_type_i = 1'b1; rd_addr_i = 5'd0; return_addr_i = 32'hDEAD;
        cyc("jal_x0", mk(M_CK, 1'b0, 0, 3'd0, 4'd0, 0, 1'b0));
        clr();
        cyc("after_x0", mk(M_CK, 1'b0, 0, 3'd0, 4'd0, 0, 1'b0));

        // Overflow: nine pushes wrap over the oldest entry.
        for (int i = 1; i <= 9; i++) begin
            clr(); jal(32'(i * 16));
            cyc("ovf_push", mk(M_CK | M_OV, 1'b0, 0, 3'(i - 1),
                               4'((i - 1 > 8) ? 8 : i - 1), 0, 1'b0));
        end
        for (int k = 0; k < 8; k++) begin
            clr(); pop();
            cyc("ovf_pop", mk(M_PV | M_PD | M_CK | M_OV, 1'b1, 32'((9 - k) * 16),
                              3'(9 - k), 4'(8 - k), 0, (k == 0)));
        end
        clr(); pop();
        cyc("ovf_pop9", mk(M_PV | M_CK | M_OV, 1'b0, 0, 3'd1, 4'd0, 0, 1'b0));

        // Repair from a checkpoint after speculative pop/push.
        clr(); rst_i = 1'b1;
        cyc("rst2", mk(M_PV, 1'b0, 0, 3'd0, 4'd0, 0, 1'b0));
        clr(); jal(32'hA0);
        cyc("rep_push", mk(M_CK | M_CD, 1'b0, 0, 3'd0, 4'd0, 0, 1'b0));
        clr();
        cyc("rep_ckpt", mk(M_CK | M_CD, 1'b0, 0, 3'd1, 4'd1, 32'hA0, 1'b0));
        clr(); pop();
        cyc("rep_spec_pop", mk(M_PV | M_PD, 1'b1, 32'hA0, 3'd1, 4'd1, 0, 1'b0));
        clr(); jal(32'hB0);
        cyc("rep_spec_push", mk(M_CK, 1'b0, 0, 3'd0, 4'd0, 0, 1'b0));
        clr(); pop(); restore(3'd1, 4'd1, 32'hA0);
        cyc("rep_restore", mk(M_PV | M_CK | M_CD, 1'b0, 0, 3'd1, 4'd1, 32'hB0, 1'b0));
        clr(); pop();
        cyc("rep_pop", mk(M_PV | M_PD | M_CK, 1'b1, 32'hA0, 3'd1, 4'd1, 0, 1'b0));

        // JALR rd=x1, rs1=x5: BOTH with alt-link, plain PUSH without.
        clr(); jal(32'h300);
        cyc("both_setup", mk(M_CK, 1'b0, 0, 3'd0, 4'd0, 0, 1'b0));
        clr(); jalr(5'd1, 5'd5, 32'h400);
        cyc("both_op", mk(M_PV | M_PD | M_CK | M_CD, BOTH_PV, 32'h300, 3'd1, 4'd1, 32'h300, 1'b0));
        clr();
        cyc("both_after", mk(M_CK | M_CD, 1'b0, 0, BOTH_TOS, BOTH_CNT, 32'h400, 1'b0));

        // Priority: restore beats flush beats request.
        clr(); rst_i = 1'b1;
        cyc("rst3", mk(M_PV, 1'b0, 0, 3'd0, 4'd0, 0, 1'b0));
        clr(); jal(32'h500);
        cyc("pri_setup", mk(M_CK, 1'b0, 0, 3'd0, 4'd0, 0, 1'b0));
        clr(); jal(32'h999); flush_i = 1'b1; restore(3'd3, 4'd2, 32'h777);
        cyc("pri_all", mk(M_PV | M_CK | M_CD, 1'b0, 0, 3'd1, 4'd1, 32'h500, 1'b0));
        clr();
        cyc("pri_after", mk(M_CK | M_CD, 1'b0, 0, 3'd3, 4'd2, 32'h777, 1'b0));
        clr(); flush_i = 1'b1;
        cyc("flush", mk(M_CK, 1'b0, 0, 3'd3, 4'd2, 0, 1'b0));
        clr(); pop();
        cyc("flush_pop", mk(M_PV | M_CK, 1'b0, 0, 3'd3, 4'd0, 0, 1'b0));

        // Reset mid-run with cnt=5 and competing restore/push.
        for (int i = 1; i <= 5; i++) begin
            clr(); jal(32'(i * 'h11));
            cyc("mid_push", mk(M_CK, 1'b0, 0, 3'(3 + i - 1), 4'(i - 1), 0, 1'b0));
        end
        clr(); rst_i = 1'b1; jal(32'h66); restore(3'd2, 4'd3, 32'h77);
        cyc("rst_mid", mk(M_PV | M_CK, 1'b0, 0, 3'd0, 4'd5, 0, 1'b0));
        clr(); pop();
        cyc("rst_mid_after", mk(M_PV | M_CK | M_CD | M_OV, 1'b0, 0, 3'd0, 4'd0, 0, 1'b0));

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
            @(negedge clk_i);
        end
        #1;
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
